// File: rtl/fetch_redirect_ctrl_if.sv
// Fetch redirect bus between the front end (master) and the redirect sequencer (slave).
interface fetch_redirect_ctrl_if #(
  parameter int ADDRESS_BITS = 32,
  parameter int COUNT_BITS   = 16
);
  logic                    stall_req;
  logic                    branch_valid;
  logic [ADDRESS_BITS-1:0] branch_target;
  logic                    trap_valid;
  logic [ADDRESS_BITS-1:0] trap_target;
  logic                    halt_req;
  logic                    resume_req;
  logic [1:0]              next_PC_select;
  logic [ADDRESS_BITS-1:0] target_PC;
  logic                    redirect_ack;
  logic                    flush;
  logic                    misaligned;
  logic [COUNT_BITS-1:0]   redirect_count;
  logic [1:0]              ctrl_state;

  modport slave (
    input  stall_req, branch_valid, branch_target, trap_valid, trap_target,
           halt_req, resume_req,
    output next_PC_select, target_PC, redirect_ack, flush, misaligned,
           redirect_count, ctrl_state
  );

  modport master (
    output stall_req, branch_valid, branch_target, trap_valid, trap_target,
           halt_req, resume_req,
    input  next_PC_select, target_PC, redirect_ack, flush, misaligned,
           redirect_count, ctrl_state
  );
endinterface

// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC sequencer: arbitrates trap/branch redirects (trap wins), holds a
// redirect across front-end stalls, applies a boot hold and debug halt.
module fetch_redirect_ctrl #(
  parameter int ADDRESS_BITS = 32,
  parameter int BOOT_CYCLES  = 4,
  parameter int COUNT_BITS   = 16
) (
  input logic                   clock,
  input logic                   reset,
  fetch_redirect_ctrl_if.slave  bus
);
  localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);
  localparam logic [1:0] SEL_INC = 2'b00, SEL_HOLD = 2'b01, SEL_LOAD = 2'b10;

  typedef enum logic [1:0] {BOOT = 2'b00, RUN = 2'b01, PEND = 2'b10, HALT = 2'b11} state_e;

  state_e                  state_q, state_d;
  logic [BW-1:0]           boot_cnt_q, boot_cnt_d;
  logic [ADDRESS_BITS-1:0] pend_tgt_q, pend_tgt_d;
  logic                    pend_trap_q, pend_trap_d;
  logic [COUNT_BITS-1:0]   cnt_q, cnt_d;

  logic [1:0]              sel;
  logic                    load;
  logic [ADDRESS_BITS-1:0] load_tgt;
  logic [ADDRESS_BITS-1:0] win_tgt, eff_tgt;
  logic                    eff_trap;

  // Next-state and same-cycle PC select/target decode.
  always_comb begin
    state_d     = state_q;
    boot_cnt_d  = boot_cnt_q;
    pend_tgt_d  = pend_tgt_q;
    pend_trap_d = pend_trap_q;
    sel         = SEL_HOLD;
    load        = 1'b0;
    load_tgt    = '0;
    win_tgt     = bus.trap_valid ? bus.trap_target : bus.branch_target;
    // A new trap replaces anything pending; a new branch only replaces a pending branch.
    eff_tgt     = pend_tgt_q;
    eff_trap    = pend_trap_q;
    if (bus.trap_valid) begin
      eff_tgt  = bus.trap_target;
      eff_trap = 1'b1;
    end else if (bus.branch_valid && !pend_trap_q) begin
      eff_tgt  = bus.branch_target;
      eff_trap = 1'b0;
    end

    case (state_q)
      BOOT: begin
        boot_cnt_d = boot_cnt_q + BW'(1);
        if (boot_cnt_q == BOOT_LAST) state_d = RUN;
      end
      RUN: begin
        if (bus.trap_valid || bus.branch_valid) begin
          if (!bus.stall_req) begin
            sel      = SEL_LOAD;
            load     = 1'b1;
            load_tgt = win_tgt;
          end else begin
            pend_tgt_d  = win_tgt;
            pend_trap_d = bus.trap_valid;
            state_d     = PEND;
          end
        end else if (bus.halt_req) begin
          state_d = HALT;
        end else if (!bus.stall_req) begin
          sel = SEL_INC;
        end
      end
      PEND: begin
        if (bus.stall_req) begin
          pend_tgt_d  = eff_tgt;
          pend_trap_d = eff_trap;
        end else begin
          sel      = SEL_LOAD;
          load     = 1'b1;
          load_tgt = eff_tgt;
          state_d  = RUN;
        end
      end
      HALT: begin
        if (bus.resume_req) state_d = RUN;
      end
      default: state_d = BOOT;
    endcase

    // Reset overrides everything visible this cycle as well as the next state.
    if (reset) begin
      sel      = SEL_HOLD;
      load     = 1'b0;
      load_tgt = '0;
    end

    cnt_d = (load && cnt_q != '1) ? cnt_q + COUNT_BITS'(1) : cnt_q;
  end

  // State, pending entry and counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= BOOT;
      boot_cnt_q  <= '0;
      pend_tgt_q  <= '0;
      pend_trap_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      pend_tgt_q  <= pend_tgt_d;
      pend_trap_q <= pend_trap_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.next_PC_select = sel;
  assign bus.target_PC      = {load_tgt[ADDRESS_BITS-1:2], 2'b00};
  assign bus.redirect_ack   = load;
  assign bus.flush          = load;
  assign bus.misaligned     = load & (|load_tgt[1:0]);
  assign bus.redirect_count = cnt_q;
  assign bus.ctrl_state     = state_q;
endmodule
